// File: rtl/bridge_arbiter.sv
// Round-robin arbiter: num_req masters share one registered downstream port; grant/bus_valid one cycle after
// request, req_done one cycle after bus_ack, requests wait while BUSY. `BRIDGE_ARBITER_TIMEOUT_EN adds a BUSY watchdog.
module bridge_arbiter #(
   parameter int num_req        = 2,
   parameter int addr_width     = 32,
   parameter int data_width     = 32,
   parameter int timeout_cycles = 255
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [num_req-1:0]               req_valid,
   input  logic [num_req-1:0]               req_write,
   input  logic [num_req*addr_width-1:0]    req_addr,
   input  logic [num_req*data_width-1:0]    req_wdata,
   output logic [num_req-1:0]               grant,
   output logic [num_req-1:0]               req_done,
   output logic [data_width-1:0]            req_rdata,
   output logic                             timeout_err,
   output logic                             bus_valid,
   output logic                             bus_write,
   output logic [addr_width-1:0]            bus_addr,
   output logic [data_width-1:0]            bus_wdata,
   input  logic                             bus_ack,
   input  logic [data_width-1:0]            bus_rdata
);

   localparam int idx_w = $clog2(num_req);

   typedef enum logic [1:0] {s_idle, s_busy, s_done} state_t;

   state_t                 state, state_nxt;
   logic [idx_w-1:0]       last, last_nxt, win_idx;
   logic                   found;
   logic [num_req-1:0]     win_oh;
   logic                   win_write;
   logic [addr_width-1:0]  win_addr;
   logic [data_width-1:0]  win_wdata;
   logic                   to_hit;
   int                     cand;

   logic [num_req-1:0]     grant_nxt, done_nxt;
   logic [data_width-1:0]  rdata_nxt, wdata_nxt;
   logic [addr_width-1:0]  addr_nxt;
   logic                   valid_nxt, write_nxt;

   // First requester with req_valid set, searching upward from last+1 and wrapping.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = 0;
      for (int k = 1; k <= num_req; k++) begin
         cand = int'(last) + k;
         if (cand >= num_req) cand = cand - num_req;
         if (!found && req_valid[cand[idx_w-1:0]]) begin
            found   = 1'b1;
            win_idx = cand[idx_w-1:0];
         end
      end
   end

   assign win_oh    = num_req'(1) << win_idx;
   assign win_write = |(req_write & win_oh);
   assign win_addr  = addr_width'(req_addr >> (int'(win_idx) * addr_width));
   assign win_wdata = data_width'(req_wdata >> (int'(win_idx) * data_width));

`ifdef BRIDGE_ARBITER_TIMEOUT_EN
   logic [15:0] tcnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                tcnt <= '0;
      else if (state != s_busy) tcnt <= '0;
      else if (!bus_ack)        tcnt <= tcnt + 16'd1;
   end

   // Abort on the cycle the count would reach the limit; a same-cycle ack wins.
   assign to_hit = !bus_ack && ((tcnt + 16'd1) == 16'(timeout_cycles));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) timeout_err <= 1'b0;
      else       timeout_err <= (state == s_busy) && to_hit;
   end
`else
   // timeout_cycles is always positive, so this never fires.
   assign to_hit      = (timeout_cycles < 0);
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      grant_nxt = grant;
      done_nxt  = '0;
      rdata_nxt = req_rdata;
      valid_nxt = bus_valid;
      write_nxt = bus_write;
      addr_nxt  = bus_addr;
      wdata_nxt = bus_wdata;
      case (state)
         s_idle: begin
            if (found) begin
               state_nxt = s_busy;
               last_nxt  = win_idx;
               grant_nxt = win_oh;
               valid_nxt = 1'b1;
               write_nxt = win_write;
               addr_nxt  = win_addr;
               wdata_nxt = win_wdata;
            end
         end
         s_busy: begin
            if (bus_ack || to_hit) begin
               state_nxt = s_done;
               valid_nxt = 1'b0;
               done_nxt  = grant;
               rdata_nxt = bus_ack ? (bus_write ? '0 : bus_rdata) : '1;
            end
         end
         s_done: begin
            grant_nxt = '0;
            state_nxt = s_idle;
         end
         default: state_nxt = s_idle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= s_idle;
         last      <= idx_w'(num_req - 1);
         grant     <= '0;
         req_done  <= '0;
         req_rdata <= '0;
         bus_valid <= 1'b0;
         bus_write <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         grant     <= grant_nxt;
         req_done  <= done_nxt;
         req_rdata <= rdata_nxt;
         bus_valid <= valid_nxt;
         bus_write <= write_nxt;
         bus_addr  <= addr_nxt;
         bus_wdata <= wdata_nxt;
      end
   end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Bench for bridge_arbiter with three requesters and a 4-cycle watchdog limit:
// directed corner cases, an arbitration vector table, and randomized traffic against a reference model.
module tb_bridge_arbiter;
   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

`ifdef BRIDGE_ARBITER_TIMEOUT_EN
   localparam bit to_en = 1'b1;
`else
   localparam bit to_en = 1'b0;
`endif

   logic            clk   = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    req_valid, req_write, grant, req_done;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   req_rdata, bus_wdata, bus_rdata;
   logic [AW-1:0]   bus_addr;
   logic            timeout_err, bus_valid, bus_write, bus_ack;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bridge_arbiter #(.num_req(N), .addr_width(AW), .data_width(DW), .timeout_cycles(TO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .grant(grant), .req_done(req_done), .req_rdata(req_rdata), .timeout_err(timeout_err),
      .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   typedef struct {
      logic [N-1:0]  valid;
      logic          wr;
      logic [DW-1:0] rdata;
      logic [N-1:0]  exp_grant;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wdata;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t vecs [10];

   // reference model of the arbiter, transaction level
   int            m_owner, m_last, m_wait;
   logic          m_done, m_terr, m_write;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      bus_ack   = 1'b0;
      bus_rdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " grant"},       64'(grant),       64'(0));
      check({tag, " req_done"},    64'(req_done),    64'(0));
      check({tag, " req_rdata"},   64'(req_rdata),   64'(0));
      check({tag, " timeout_err"}, 64'(timeout_err), 64'(0));
      check({tag, " bus_valid"},   64'(bus_valid),   64'(0));
      check({tag, " bus_write"},   64'(bus_write),   64'(0));
      check({tag, " bus_addr"},    64'(bus_addr),    64'(0));
      check({tag, " bus_wdata"},   64'(bus_wdata),   64'(0));
   endtask

   task automatic run_random(input int cycles);
      logic [N-1:0] eg;
      logic         found;
      int           c;
      do_reset();
      m_owner = -1; m_last = N - 1; m_wait = 0;
      m_done = 1'b0; m_terr = 1'b0; m_write = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      for (int cyc = 0; cyc < cycles; cyc++) begin
         tick();
         eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
         check("rnd grant",       64'(grant),       64'(eg));
         check("rnd bus_valid",   64'(bus_valid),   64'(m_owner >= 0 && !m_done));
         check("rnd req_done",    64'(req_done),    64'(m_done ? eg : '0));
         check("rnd timeout_err", 64'(timeout_err), 64'(m_done && m_terr));
         if (m_owner >= 0 && !m_done) begin
            check("rnd bus_addr",  64'(bus_addr),  64'(m_addr));
            check("rnd bus_wdata", 64'(bus_wdata), 64'(m_wdata));
            check("rnd bus_write", 64'(bus_write), 64'(m_write));
         end
         if (m_done) check("rnd req_rdata", 64'(req_rdata), 64'(m_rdata));

         for (int i = 0; i < N; i++) begin
            if (req_done[i])
               req_valid[i] = 1'b0;
            else if (!req_valid[i] && !grant[i]) begin
               if ($urandom_range(0, 3) == 0) req_valid[i] = 1'b1;
            end else if (req_valid[i] && grant[i] && $urandom_range(0, 15) == 0)
               req_valid[i] = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
               req_write[i]          = 1'($urandom_range(0, 1));
               req_addr[i*AW +: AW]  = $urandom;
               req_wdata[i*DW +: DW] = $urandom;
            end
         end
         bus_ack   = bus_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 1);
         bus_rdata = $urandom;

         if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
               c = (m_last + k) % N;
               if (!found && req_valid[c]) begin
                  found   = 1'b1;
                  m_owner = c;
                  m_last  = c;
                  m_wait  = 0;
                  m_write = req_write[c];
                  m_addr  = req_addr[c*AW +: AW];
                  m_wdata = req_wdata[c*DW +: DW];
               end
            end
         end else if (m_done) begin
            m_done  = 1'b0;
            m_owner = -1;
         end else if (bus_ack) begin
            m_done  = 1'b1;
            m_terr  = 1'b0;
            m_rdata = m_write ? '0 : bus_rdata;
         end else begin
            m_wait++;
            if (to_en && m_wait == TO) begin
               m_done  = 1'b1;
               m_terr  = 1'b1;
               m_rdata = '1;
            end
         end
      end
   endtask

   initial begin
      logic [N-1:0] eg;
      logic         ev;

      vecs[0] = '{3'b111, 1'b0, 32'h0000_00A0, 3'b001, 32'h1000_0000, 32'hD000_0000, 32'h0000_00A0};
      vecs[1] = '{3'b111, 1'b1, 32'h0000_00A1, 3'b010, 32'h1000_0010, 32'hD000_0001, 32'h0000_0000};
      vecs[2] = '{3'b111, 1'b0, 32'h0000_00A2, 3'b100, 32'h1000_0020, 32'hD000_0002, 32'h0000_00A2};
      vecs[3] = '{3'b110, 1'b0, 32'h0000_00A3, 3'b010, 32'h1000_0010, 32'hD000_0001, 32'h0000_00A3};
      vecs[4] = '{3'b011, 1'b1, 32'h0000_00A4, 3'b001, 32'h1000_0000, 32'hD000_0000, 32'h0000_0000};
      vecs[5] = '{3'b101, 1'b0, 32'h0000_00A5, 3'b100, 32'h1000_0020, 32'hD000_0002, 32'h0000_00A5};
      vecs[6] = '{3'b100, 1'b1, 32'h0000_00A6, 3'b100, 32'h1000_0020, 32'hD000_0002, 32'h0000_0000};
      vecs[7] = '{3'b010, 1'b0, 32'h0000_00A7, 3'b010, 32'h1000_0010, 32'hD000_0001, 32'h0000_00A7};
      vecs[8] = '{3'b001, 1'b0, 32'h0000_00A8, 3'b001, 32'h1000_0000, 32'hD000_0000, 32'h0000_00A8};
      vecs[9] = '{3'b011, 1'b0, 32'h0000_00A9, 3'b010, 32'h1000_0010, 32'hD000_0001, 32'h0000_00A9};

      clear_inputs();
      #1 reset = 1'b1;
      #1 check_all_zero("reset");

      // single read, ack in cycle 3
      do_reset();
      tick();
      req_valid = 3'b001;
      req_addr[0 +: AW] = 32'h0000_0010;
      tick();
      check("read c1 grant",     64'(grant),     64'(3'b001));
      check("read c1 bus_valid", 64'(bus_valid), 64'(1));
      check("read c1 bus_addr",  64'(bus_addr),  64'(32'h0000_0010));
      check("read c1 bus_write", 64'(bus_write), 64'(0));
      tick();
      check("read c2 bus_valid", 64'(bus_valid), 64'(1));
      tick();
      check("read c3 bus_valid", 64'(bus_valid), 64'(1));
      check("read c3 req_done",  64'(req_done),  64'(0));
      bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
      tick();
      check("read c4 bus_valid", 64'(bus_valid), 64'(0));
      check("read c4 req_done",  64'(req_done),  64'(3'b001));
      check("read c4 req_rdata", 64'(req_rdata), 64'(32'hCAFE_F00D));
      bus_ack = 1'b0; req_valid = '0;
      tick();
      check("read c5 grant",     64'(grant),     64'(0));
      check("read c5 req_done",  64'(req_done),  64'(0));

      // contention with zero-wait acks
      do_reset();
      tick();
      req_valid = 3'b011;
      for (int c = 1; c <= 8; c++) begin
         tick();
         ev = (c % 3 == 1);
         if (c % 3 == 0)                eg = 3'b000;
         else if (((c - 1) / 3) % 2 == 0) eg = 3'b001;
         else                           eg = 3'b010;
         check("contention bus_valid", 64'(bus_valid), 64'(ev));
         check("contention grant",     64'(grant),     64'(eg));
         bus_ack = bus_valid;
      end
      req_valid = '0; bus_ack = 1'b0;
      tick();

      // write by requester 1, inputs changed mid-transaction
      do_reset();
      tick();
      req_valid = 3'b010; req_write = 3'b010;
      req_addr[AW +: AW] = 32'h0000_0040; req_wdata[DW +: DW] = 32'h1234_5678;
      for (int c = 1; c <= 4; c++) begin
         tick();
         check("write grant",     64'(grant),     64'(3'b010));
         check("write bus_valid", 64'(bus_valid), 64'(1));
         check("write bus_write", 64'(bus_write), 64'(1));
         check("write bus_addr",  64'(bus_addr),  64'(32'h0000_0040));
         check("write bus_wdata", 64'(bus_wdata), 64'(32'h1234_5678));
         if (c == 2) begin
            req_addr[AW +: AW] = 32'h0000_BAD0; req_wdata[DW +: DW] = 32'h0000_BAD1;
         end
         if (c == 4) begin
            bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
         end
      end
      tick();
      check("write req_done",  64'(req_done),  64'(3'b010));
      check("write req_rdata", 64'(req_rdata), 64'(0));
      bus_ack = 1'b0; req_valid = '0; req_write = '0;
      tick();

      // requester abandons mid-transaction
      do_reset();
      tick();
      req_valid = 3'b001; req_addr[0 +: AW] = 32'h0000_0020;
      tick();
      check("abandon grant", 64'(grant), 64'(3'b001));
      req_valid = '0;
      tick();
      check("abandon bus_valid held", 64'(bus_valid), 64'(1));
      bus_ack = 1'b1; bus_rdata = 32'h55AA_1234;
      tick();
      check("abandon req_done",  64'(req_done),  64'(3'b001));
      check("abandon req_rdata", 64'(req_rdata), 64'(32'h55AA_1234));
      bus_ack = 1'b0;
      tick();
      check("abandon grant clear", 64'(grant), 64'(0));

      // reset while BUSY
      do_reset();
      tick();
      req_valid = 3'b001; req_write = 3'b001;
      req_addr[0 +: AW] = 32'h0000_0088; req_wdata[0 +: DW] = 32'hFACE_0001;
      tick();
      check("rstbusy c1 bus_valid", 64'(bus_valid), 64'(1));
      tick();
      reset = 1'b1;
      #1 check_all_zero("rstbusy async");
      req_valid = 3'b011; req_write = '0;
      @(negedge clk);
      reset = 1'b0;
      tick();
      check("rstbusy first grant", 64'(grant),    64'(3'b001));
      check("rstbusy no done",     64'(req_done), 64'(0));
      bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
      tick();
      check("rstbusy done", 64'(req_done), 64'(3'b001));
      bus_ack = 1'b0; req_valid = '0;
      tick();

`ifdef BRIDGE_ARBITER_TIMEOUT_EN
      // no ack: abort after the limit
      do_reset();
      tick();
      req_valid = 3'b001; req_addr[0 +: AW] = 32'h0000_0030;
      for (int c = 1; c <= TO; c++) begin
         tick();
         check("timeout bus_valid",   64'(bus_valid),   64'(1));
         check("timeout early done",  64'(req_done),    64'(0));
         check("timeout early err",   64'(timeout_err), 64'(0));
      end
      tick();
      check("timeout bus_valid off", 64'(bus_valid),   64'(0));
      check("timeout req_done",      64'(req_done),    64'(3'b001));
      check("timeout err",           64'(timeout_err), 64'(1));
      check("timeout rdata",         64'(req_rdata),   64'(32'hFFFF_FFFF));
      req_valid = '0;
      tick();
      check("timeout err clear", 64'(timeout_err), 64'(0));
      check("timeout grant",     64'(grant),       64'(0));

      // ack exactly on the limit cycle
      do_reset();
      tick();
      req_valid = 3'b001;
      for (int c = 1; c <= TO; c++) begin
         tick();
         check("boundary bus_valid", 64'(bus_valid), 64'(1));
         if (c == TO) begin
            bus_ack = 1'b1; bus_rdata = 32'h600D_CAFE;
         end
      end
      tick();
      check("boundary req_done", 64'(req_done),    64'(3'b001));
      check("boundary err",      64'(timeout_err), 64'(0));
      check("boundary rdata",    64'(req_rdata),   64'(32'h600D_CAFE));
      bus_ack = 1'b0; req_valid = '0;
      tick();
`else
      // without the watchdog BUSY waits for the ack
      do_reset();
      tick();
      req_valid = 3'b001;
      for (int c = 1; c <= 2 * TO; c++) begin
         tick();
         check("nowdog bus_valid", 64'(bus_valid),   64'(1));
         check("nowdog err",       64'(timeout_err), 64'(0));
         check("nowdog done",      64'(req_done),    64'(0));
      end
      bus_ack = 1'b1; bus_rdata = 32'h0000_0001;
      tick();
      check("nowdog req_done", 64'(req_done),  64'(3'b001));
      check("nowdog rdata",    64'(req_rdata), 64'(1));
      bus_ack = 1'b0; req_valid = '0;
      tick();
`endif

      // arbitration vector table, one zero-wait transaction per row
      do_reset();
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW]  = 32'h1000_0000 + 16 * i;
         req_wdata[i*DW +: DW] = 32'hD000_0000 + i;
      end
      tick();
      for (int v = 0; v < 10; v++) begin
         req_valid = vecs[v].valid;
         req_write = {N{vecs[v].wr}};
         tick();
         check("table grant",     64'(grant),     64'(vecs[v].exp_grant));
         check("table bus_valid", 64'(bus_valid), 64'(1));
         check("table bus_write", 64'(bus_write), 64'(vecs[v].wr));
         check("table bus_addr",  64'(bus_addr),  64'(vecs[v].exp_addr));
         check("table bus_wdata", 64'(bus_wdata), 64'(vecs[v].exp_wdata));
         bus_ack = 1'b1; bus_rdata = vecs[v].rdata;
         tick();
         check("table req_done",  64'(req_done),  64'(vecs[v].exp_grant));
         check("table req_rdata", 64'(req_rdata), 64'(vecs[v].exp_rdata));
         bus_ack = 1'b0; req_valid = '0;
         tick();
         check("table idle grant", 64'(grant), 64'(0));
      end

      run_random(3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bridge_arbiter.md
# bridge_arbiter

Round-robin arbiter that shares one one-way request/response bus port (address, write data, write strobe out; read data, ack back) between `num_req` requesters. It sits between several masters (core, DMA, host-bridge command handler) and a single downstream register/memory port. It latches the winning request, drives it downstream until acknowledged, and returns read data and a completion pulse to the winner only. All downstream outputs are registered, so driven nets have a single unidirectional source.

## Interface
- `num_req`, default 2: number of requesters, legal 2..8
- `addr_width`, default 32: address width
- `data_width`, default 32: data width
- `timeout_cycles`, default 255: watchdog limit in cycles, legal 1..65535; used only with the timeout feature
- `clk`  input  1  single clock for all logic
- `reset`  input  1  asynchronous, active-high reset
- `req_valid`  input  num_req  per-requester request; held until that requester's `req_done`
- `req_write`  input  num_req  1 = write, 0 = read
- `req_addr`  input  num_req*addr_width  flattened; requester i at bits [i*addr_width +: addr_width]
- `req_wdata`  input  num_req*data_width  flattened, same packing as `req_addr`
- `grant`  output  num_req  one-hot current owner; 0 when idle
- `req_done`  output  num_req  one-cycle completion pulse to the owner
- `req_rdata`  output  data_width  read data, valid while `req_done` is high
- `timeout_err`  output  1  pulses with `req_done` when a transaction is aborted
- `bus_valid`  output  1  downstream request
- `bus_write`  output  1  downstream direction
- `bus_addr`  output  addr_width  downstream address
- `bus_wdata`  output  data_width  downstream write data
- `bus_ack`  input  1  downstream completion, sampled only while `bus_valid` = 1
- `bus_rdata`  input  data_width  downstream read data, sampled on the `bus_ack` cycle

## Operation
- States: IDLE, BUSY, DONE. Reset goes to IDLE. All outputs reset to 0. The round-robin pointer `last` resets to `num_req-1`, so requester 0 wins first.
- IDLE: if any `req_valid` is high, pick the first requester searching from `last+1` (mod `num_req`) upward. Register `grant`, `bus_write`, `bus_addr` and `bus_wdata` from the winner, set `bus_valid` = 1, set `last` to the winner, and go to BUSY.
- BUSY: hold all bus outputs stable. When `bus_ack` = 1, capture `bus_rdata` into `req_rdata`. For writes, `req_rdata` is loaded with 0. Clear `bus_valid` and go to DONE.
- DONE: `req_done[winner]` = 1 for exactly this cycle, then clear `grant` and go to IDLE.
- Requesters deassert `req_valid` no later than the cycle after `req_done`. A `req_valid` still high in IDLE is treated as a new request.
- If a requester drops `req_valid` mid-transaction, the transaction still completes; `req_done` still pulses.
- Changes to a non-granted requester's inputs have no effect on the bus.
- Asserting `reset` in any state aborts the in-flight transaction immediately: outputs go to 0, there is no `req_done`, and the state returns to IDLE.

## Timing
- A request arriving in IDLE at cycle 0 gives `grant` and `bus_valid` = 1 in cycle 1.
- `bus_ack` in cycle k gives `bus_valid` = 0 and `req_done` = 1 in cycle k+1, and IDLE in cycle k+2. The earliest next `bus_valid` is cycle k+3.
- Zero-wait downstream (ack in cycle 1): one transaction per 3 cycles.
- Fairness: a continuously requesting requester waits at most `num_req-1` transactions.

## Configuration
- `BRIDGE_ARBITER_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without `bus_ack`.
  - When the counter reaches `timeout_cycles`, the transaction is aborted: `bus_valid` = 0 next cycle and the state goes to DONE.
  - `req_rdata` = all ones and `timeout_err` = 1 together with `req_done`.
  - An ack arriving on the same cycle as the limit takes priority and is a normal completion.
- Not defined: no counter; BUSY waits indefinitely and `timeout_err` is constant 0.

## Test plan
- Single read: `num_req` = 2, req 0 reads 0x0000_0010, ack in cycle 3 with `bus_rdata` = 0xCAFE_F00D -> `bus_valid` high in cycles 1-3, `req_done[0]` in cycle 4 with `req_rdata` = 0xCAFE_F00D, `grant` = 0 in cycle 5.
- Contention: reqs 0 and 1 both high from reset, zero-wait acks -> `grant` sequence 01, 10, 01 with `bus_valid` starting in cycles 1, 4, 7.
- Write: req 1 writes 0x1234_5678 to 0x40 -> `bus_write` = 1, `bus_addr` = 0x40, `bus_wdata` = 0x1234_5678 held stable until ack; `req_rdata` = 0 on `req_done`.
- Abandon and reset: req 0 drops `req_valid` in BUSY -> `req_done[0]` still pulses. Separately, `reset` pulsed in BUSY -> all outputs 0 asynchronously, no `req_done`, and req 0 wins first after release.
- Timeout (macro on, `timeout_cycles` = 4): no ack -> `bus_valid` = 0 in cycle 5, `req_done` and `timeout_err` = 1 with `req_rdata` = 0xFFFF_FFFF.
- Timeout boundary: ack in exactly the limit cycle -> normal completion, `timeout_err` = 0.
